// File: rtl/sram_arbiter.sv
// sram_arbiter: single-port owner of the external 48-bit SRAM.
// Grants one word access at a time to VGA, GPU master, GPU slave or system bus.
// VGA has priority, but only for a bounded run of grants while others wait.
// The other three requesters share the SRAM round-robin.
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int VGA_BURST     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] vga_addr,
   input  logic        vga_sel,
   output logic        vga_valid,
   input  logic [19:0] m_addr,
   input  logic [47:0] m_wdata,
   input  logic        m_sel,
   input  logic        m_we,
   output logic        m_valid,
   input  logic [19:0] s_addr,
   input  logic [47:0] s_wdata,
   input  logic        s_sel,
   input  logic        s_we,
   output logic        s_valid,
   input  logic [19:0] b_addr,
   input  logic [47:0] b_wdata,
   input  logic        b_sel,
   input  logic        b_we,
   output logic        b_valid,
   output logic [47:0] rd_data,
   output logic [19:0] sram_addr,
   input  logic [47:0] sram_dq_i,
   output logic [47:0] sram_dq_o,
   output logic        sram_dq_oe,
   output logic        sram_ce,
   output logic        sram_oen,
   output logic        sram_wen,
   output logic        busy
);
   localparam int CW = $clog2(ACCESS_CYCLES + 1);
   localparam int SW = $clog2(VGA_BURST + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Owner codes: 0 = VGA, 1 = master, 2 = slave, 3 = bus.
   // Round-robin pointer codes: 0 = master, 1 = slave, 2 = bus.
   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [SW-1:0] streak_reg;
   logic [1:0]    rr_ptr_reg;
   logic [1:0]    owner_reg;
   logic          we_reg;

   logic          grant;
   logic [1:0]    win;
   logic [1:0]    win_rr_next;
   logic          win_we;
   logic [19:0]   win_addr;
   logic [47:0]   win_wdata;
   logic [2:0]    req;

   // Candidate k positions after the pointer, wrapping m->s->b->m.
   function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
      int t;
      t = int'(p) + k;
      if (t >= 3) t = t - 3;
      return 2'(t);
   endfunction

   assign req = {b_sel, s_sel, m_sel};

   // Winner selection, only meaningful while IDLE.
   always_comb begin
      grant       = 1'b0;
      win         = 2'd0;
      win_rr_next = rr_ptr_reg;
      win_we      = 1'b0;
      win_addr    = '0;
      win_wdata   = '0;
      if (vga_sel && !((streak_reg == SW'(VGA_BURST)) && (|req))) begin
         grant    = 1'b1;
         win      = 2'd0;
         win_addr = vga_addr;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (!grant && req[rr_idx(rr_ptr_reg, k)]) begin
               grant       = 1'b1;
               win         = rr_idx(rr_ptr_reg, k) + 2'd1;
               win_rr_next = rr_idx(rr_ptr_reg, k + 1);
               case (rr_idx(rr_ptr_reg, k))
                  2'd0:    begin win_we = m_we; win_addr = m_addr; win_wdata = m_wdata; end
                  2'd1:    begin win_we = s_we; win_addr = s_addr; win_wdata = s_wdata; end
                  default: begin win_we = b_we; win_addr = b_addr; win_wdata = b_wdata; end
               endcase
            end
         end
      end
   end

   // State register plus the access context latched at grant time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         streak_reg <= '0;
         rr_ptr_reg <= 2'd0;
         owner_reg  <= 2'd0;
         we_reg     <= 1'b0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         rd_data    <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (grant) begin
                  owner_reg <= win;
                  we_reg    <= win_we;
                  sram_addr <= win_addr;
                  sram_dq_o <= win_wdata;
                  cnt_reg   <= CW'(ACCESS_CYCLES);
                  if (win == 2'd0) begin
                     if (streak_reg != SW'(VGA_BURST)) streak_reg <= streak_reg + SW'(1);
                  end else begin
                     streak_reg <= '0;
                     rr_ptr_reg <= win_rr_next;
                  end
               end
            end
            ACCESS: begin
               cnt_reg <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1) && !we_reg) rd_data <= sram_dq_i;
            end
            default: ;
         endcase
      end
   end

   // Next state, SRAM strobes and completion pulses.
   always_comb begin
      state_next = state_reg;
      sram_ce    = 1'b1;
      sram_oen   = 1'b1;
      sram_wen   = 1'b1;
      sram_dq_oe = 1'b0;
      vga_valid  = 1'b0;
      m_valid    = 1'b0;
      s_valid    = 1'b0;
      b_valid    = 1'b0;
      case (state_reg)
         IDLE: if (grant) state_next = ACCESS;
         ACCESS: begin
            sram_ce = 1'b0;
            if (we_reg) begin
               sram_wen   = 1'b0;
               sram_dq_oe = 1'b1;
            end else begin
               sram_oen = 1'b0;
            end
            if (cnt_reg == CW'(1)) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
            case (owner_reg)
               2'd0:    vga_valid = 1'b1;
               2'd1:    m_valid   = 1'b1;
               2'd2:    s_valid   = 1'b1;
               default: b_valid   = 1'b1;
            endcase
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of strobe sequencing, latency, arbitration and reset abort.
module tb_sram_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] vga_addr, m_addr, s_addr, b_addr;
   logic        vga_sel, m_sel, s_sel, b_sel;
   logic        m_we, s_we, b_we;
   logic [47:0] m_wdata, s_wdata, b_wdata;
   logic        vga_valid, m_valid, s_valid, b_valid;
   logic [47:0] rd_data, sram_dq_i, sram_dq_o;
   logic [19:0] sram_addr;
   logic        sram_dq_oe, sram_ce, sram_oen, sram_wen, busy;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int q_code[$];
   int q_cyc[$];

   always #5 clk = ~clk;

   sram_arbiter #(.ACCESS_CYCLES(2), .VGA_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .vga_addr(vga_addr), .vga_sel(vga_sel), .vga_valid(vga_valid),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel), .m_we(m_we), .m_valid(m_valid),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we), .s_valid(s_valid),
      .b_addr(b_addr), .b_wdata(b_wdata), .b_sel(b_sel), .b_we(b_we), .b_valid(b_valid),
      .rd_data(rd_data), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
      .sram_dq_oe(sram_dq_oe), .sram_ce(sram_ce), .sram_oen(sram_oen), .sram_wen(sram_wen),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {ce, oen, wen, dq_oe}
   task automatic chk_strobes(input string tag, input logic [3:0] exp);
      chk(tag, {sram_ce, sram_oen, sram_wen, sram_dq_oe}, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vga_sel = 1'b0; m_sel = 1'b0; s_sel = 1'b0; b_sel = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Run n cycles, logging which requester pulsed valid and when.
   task automatic collect(input int n);
      int cnt;
      q_code.delete();
      q_cyc.delete();
      for (int i = 1; i <= n; i++) begin
         tick();
         cnt = int'(vga_valid) + int'(m_valid) + int'(s_valid) + int'(b_valid);
         chk("valid_onehot", (cnt <= 1), 1);
         if (vga_valid) begin q_code.push_back(0); q_cyc.push_back(i); end
         if (m_valid)   begin q_code.push_back(1); q_cyc.push_back(i); end
         if (s_valid)   begin q_code.push_back(2); q_cyc.push_back(i); end
         if (b_valid)   begin q_code.push_back(3); q_cyc.push_back(i); end
      end
   endtask

   initial begin
      int exp3[6];
      int exp4[10];
      rst = 1'b1;
      vga_addr = 20'h00F00; m_addr = '0; s_addr = '0; b_addr = '0;
      m_wdata = '0; s_wdata = '0; b_wdata = '0;
      m_we = 1'b0; s_we = 1'b0; b_we = 1'b0;
      sram_dq_i = '0;
      do_reset();

      // Reset state
      chk_strobes("rst_strobes", 4'b1110);
      chk("rst_addr", sram_addr, 0);
      chk("rst_dq_o", sram_dq_o, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_valids", {vga_valid, m_valid, s_valid, b_valid}, 0);
      chk("rst_busy", busy, 0);

      // 1: master read
      m_addr = 20'h00010; m_we = 1'b0; m_sel = 1'b1;
      sram_dq_i = 48'h123456789ABC;
      tick();
      chk_strobes("t1_acc1_strobes", 4'b0010);
      chk("t1_acc1_addr", sram_addr, 20'h00010);
      chk("t1_acc1_valid", m_valid, 0);
      chk("t1_acc1_busy", busy, 1);
      tick();
      chk_strobes("t1_acc2_strobes", 4'b0010);
      m_sel = 1'b0;
      tick();
      chk_strobes("t1_done_strobes", 4'b1110);
      chk("t1_done_mvalid", m_valid, 1);
      chk("t1_rd_data", rd_data, 48'h123456789ABC);
      tick();
      chk("t1_idle_mvalid", m_valid, 0);
      chk("t1_idle_busy", busy, 0);

      // 2: master write
      m_addr = 20'h0ABCD; m_wdata = 48'hFFFF0000AAAA; m_we = 1'b1; m_sel = 1'b1;
      tick();
      sram_dq_i = 48'hDEADDEADDEAD;
      chk_strobes("t2_acc1_strobes", 4'b0101);
      chk("t2_addr", sram_addr, 20'h0ABCD);
      chk("t2_dq_o", sram_dq_o, 48'hFFFF0000AAAA);
      tick();
      chk_strobes("t2_acc2_strobes", 4'b0101);
      m_sel = 1'b0; m_we = 1'b0;
      tick();
      chk_strobes("t2_done_strobes", 4'b1110);
      chk("t2_done_mvalid", m_valid, 1);
      chk("t2_rd_data_kept", rd_data, 48'h123456789ABC);
      tick();
      chk("t2_idle_mvalid", m_valid, 0);

      // 3: m, s, b held high -> m,s,b,m,s,b every 4 cycles
      do_reset();
      m_sel = 1'b1; s_sel = 1'b1; b_sel = 1'b1;
      collect(24);
      m_sel = 1'b0; s_sel = 1'b0; b_sel = 1'b0;
      exp3 = '{1, 2, 3, 1, 2, 3};
      chk("t3_count", q_code.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t3_order%0d", i), (i < q_code.size()) ? q_code[i] : -1, exp3[i]);
         chk($sformatf("t3_cycle%0d", i), (i < q_cyc.size()) ? q_cyc[i] : -1, 3 + 4 * i);
      end
      tick();
      tick();

      // 4: vga + m held -> 4 vga, 1 m, repeat; then vga alone forever
      do_reset();
      sram_dq_i = 48'h0000CAFEF00D;
      vga_sel = 1'b1; m_sel = 1'b1; m_we = 1'b0; m_addr = 20'h00020;
      collect(40);
      m_sel = 1'b0;
      exp4 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      chk("t4_count", q_code.size(), 10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("t4_order%0d", i), (i < q_code.size()) ? q_code[i] : -1, exp4[i]);
      chk("t4_vga_rd_data", rd_data, 48'h0000CAFEF00D);
      collect(20);
      vga_sel = 1'b0;
      chk("t4b_count", q_code.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4b_code%0d", i), (i < q_code.size()) ? q_code[i] : -1, 0);
         chk($sformatf("t4b_cycle%0d", i), (i < q_cyc.size()) ? q_cyc[i] : -1, 3 + 4 * i);
      end
      tick();
      tick();

      // 5: reset during first ACCESS cycle of a slave read
      do_reset();
      s_sel = 1'b1; s_we = 1'b0; s_addr = 20'h00555;
      tick();
      chk_strobes("t5_acc1_strobes", 4'b0010);
      chk("t5_acc1_addr", sram_addr, 20'h00555);
      rst = 1'b1; m_sel = 1'b1;
      tick();
      chk_strobes("t5_rst_strobes", 4'b1110);
      chk("t5_rst_svalid", s_valid, 0);
      chk("t5_rst_busy", busy, 0);
      rst = 1'b0;
      collect(8);
      m_sel = 1'b0; s_sel = 1'b0;
      chk("t5_count", q_code.size(), 2);
      chk("t5_first_m", (q_code.size() > 0) ? q_code[0] : -1, 1);
      chk("t5_then_s", (q_code.size() > 1) ? q_code[1] : -1, 2);
      chk("t5_first_cycle", (q_cyc.size() > 0) ? q_cyc[0] : -1, 3);
      tick();
      tick();

      // 6: m_sel dropped in first ACCESS cycle
      do_reset();
      m_sel = 1'b1; m_we = 1'b0; m_addr = 20'h00077;
      tick();
      chk("t6_busy", busy, 1);
      m_sel = 1'b0;
      collect(10);
      chk("t6_count", q_code.size(), 1);
      chk("t6_code", (q_code.size() > 0) ? q_code[0] : -1, 1);
      chk("t6_cycle", (q_cyc.size() > 0) ? q_cyc[0] : -1, 2);
      chk("t6_idle", busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
